// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver.
// Two-flop synchronizer, mid-bit sampling FSM, and a one-entry output
// register with a valid/ready handshake that runs independently of the FSM.
module uart_rx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t               state, state_n;
  logic [CNT_W-1:0]     clk_cnt, clk_cnt_n;
  logic [BIT_W-1:0]     bit_cnt, bit_cnt_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic                 rx_meta, rx_s;
  logic                 deliver, stop_bad;

  // rx is asynchronous to clk; the FSM only ever sees rx_s. Idle-high reset
  // so a reset release never looks like a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // FSM state, counters and shift register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      clk_cnt <= '0;
      bit_cnt <= '0;
      shift   <= '0;
    end else begin
      state   <= state_n;
      clk_cnt <= clk_cnt_n;
      bit_cnt <= bit_cnt_n;
      shift   <= shift_n;
    end
  end

  // Next-state logic; deliver/stop_bad mark the stop-bit sample outcome.
  always_comb begin
    state_n   = state;
    clk_cnt_n = clk_cnt;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    deliver   = 1'b0;
    stop_bad  = 1'b0;
    case (state)
      S_IDLE: begin
        if (!rx_s) begin
          state_n   = S_START;
          clk_cnt_n = '0;
        end
      end
      S_START: begin
        // Resample at mid start bit; a high line here was a glitch.
        if (clk_cnt == CNT_HALF) begin
          clk_cnt_n = '0;
          bit_cnt_n = '0;
          state_n   = rx_s ? S_IDLE : S_DATA;
        end else begin
          clk_cnt_n = clk_cnt + CNT_W'(1);
        end
      end
      S_DATA: begin
        // LSB arrives first: insert at MSB and shift right.
        if (clk_cnt == CNT_LAST) begin
          clk_cnt_n = '0;
          shift_n   = {rx_s, shift[DATA_BITS-1:1]};
          bit_cnt_n = bit_cnt + BIT_W'(1);
          if (bit_cnt == BIT_LAST) state_n = S_STOP;
        end else begin
          clk_cnt_n = clk_cnt + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (clk_cnt == CNT_LAST) begin
          clk_cnt_n = '0;
          if (rx_s) begin
            deliver = 1'b1;
            state_n = S_IDLE;
          end else begin
            stop_bad = 1'b1;
            state_n  = S_BREAK;
          end
        end else begin
          clk_cnt_n = clk_cnt + CNT_W'(1);
        end
      end
      S_BREAK: begin
        // Wait out a held-low line so it reports only one framing error.
        if (rx_s) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Output register and handshake; a byte arriving while the previous one
  // is unaccepted is dropped and flagged, unless it is accepted this cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_bad;
      overrun   <= 1'b0;
      if (deliver) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shift;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames at 16 clk/bit; expected bytes are queued by the
// stimulus and popped by a monitor at each valid/ready handshake.
module tb_uart_rx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int checks = 0;
  int passes = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int fe0, ov0;
  logic [7:0] exp_q[$];

  uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
    .clk(clk), .reset(reset), .rx(rx),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act === exp) passes = passes + 1;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  // inputs change 1 time unit after the rising edge
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // start + 8 data bits LSB first + stop bit of the given level
  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = stop;
    tick(CPB);
  endtask

  // Monitor: counts flag pulses and scores every handshake.
  always @(negedge clk) begin
    if (frame_err) fe_cnt = fe_cnt + 1;
    if (overrun) ov_cnt = ov_cnt + 1;
    if (rx_valid && rx_ready) begin
      if (exp_q.size() == 0) begin
        checks = checks + 1;
        $display("FAIL handshake_unexpected: got %02h want no byte", rx_data);
      end else begin
        chk("handshake_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    rx = 1'b1;
    rx_ready = 1'b0;
    tick(3);
    @(negedge clk);
    chk("rst_valid", rx_valid, 0);
    chk("rst_data", rx_data, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    tick(5);

    // 0xA5, consumer not ready: byte held until a ready pulse
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    tick(20);
    @(negedge clk);
    chk("a5_valid_held", rx_valid, 1);
    chk("a5_data", rx_data, 8'hA5);
    @(posedge clk); #1;
    rx_ready = 1'b1;
    @(posedge clk); #1;
    rx_ready = 1'b0;
    @(negedge clk);
    chk("a5_valid_clear", rx_valid, 0);

    // back-to-back 0x00, 0xFF with ready held high
    fe0 = fe_cnt; ov0 = ov_cnt;
    rx_ready = 1'b1;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    rx = 1'b1;
    tick(20);
    rx_ready = 1'b0;
    @(negedge clk);
    chk("b2b_queue_empty", exp_q.size(), 0);
    chk("b2b_no_ferr", fe_cnt - fe0, 0);
    chk("b2b_no_ovr", ov_cnt - ov0, 0);
    chk("b2b_last_data", rx_data, 8'hFF);
    chk("b2b_valid", rx_valid, 0);

    // overrun: 0x3C unaccepted, then 0x81 arrives and is dropped
    fe0 = fe_cnt; ov0 = ov_cnt;
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    send_frame(8'h81, 1'b1);
    tick(20);
    @(negedge clk);
    chk("ovr_pulses", ov_cnt - ov0, 1);
    chk("ovr_data_kept", rx_data, 8'h3C);
    chk("ovr_valid", rx_valid, 1);
    @(posedge clk); #1;
    rx_ready = 1'b1;
    @(posedge clk); #1;
    rx_ready = 1'b0;
    @(negedge clk);
    chk("ovr_valid_clear", rx_valid, 0);
    chk("ovr_queue_empty", exp_q.size(), 0);

    // framing error: 0x55 with low stop bit, line held low 40 more clocks
    fe0 = fe_cnt; ov0 = ov_cnt;
    send_frame(8'h55, 1'b0);
    tick(40);
    @(negedge clk);
    chk("ferr_busy_low", busy, 1);
    chk("ferr_pulse", fe_cnt - fe0, 1);
    @(posedge clk); #1;
    rx = 1'b1;
    tick(6);
    @(negedge clk);
    chk("ferr_busy_released", busy, 0);
    chk("ferr_single", fe_cnt - fe0, 1);
    chk("ferr_no_valid", rx_valid, 0);

    // 4-clock glitch is rejected at the mid-start resample
    fe0 = fe_cnt;
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(2);
    @(negedge clk);
    chk("glitch_seen", busy, 1);
    tick(20);
    @(negedge clk);
    chk("glitch_idle", busy, 0);
    chk("glitch_no_valid", rx_valid, 0);
    chk("glitch_no_ferr", fe_cnt - fe0, 0);

    // reset in the middle of 0x5A's data bits, then a clean 0xC3
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 3; i++) begin
      rx = (8'h5A >> i) & 8'h01;
      tick(CPB);
    end
    reset = 1'b1;
    rx = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", rx_valid, 0);
    chk("mid_rst_data", rx_data, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ferr", frame_err, 0);
    chk("mid_rst_ovr", overrun, 0);
    tick(3);
    reset = 1'b0;
    tick(5);
    rx_ready = 1'b1;
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1);
    tick(20);
    rx_ready = 1'b0;
    @(negedge clk);
    chk("c3_queue_empty", exp_q.size(), 0);
    chk("c3_data", rx_data, 8'hC3);

    chk("total_ferr", fe_cnt, 1);
    chk("total_ovr", ov_cnt, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
